wb_stage: RTL and testbench

//  Parametrised, clocked writeback stage of the Harvard pipeline. Consumes execution-result (ER) words

---
 rtl/wb_pkg.sv | 43 ++++
 rtl/wb_queue.sv | 106 ++++++++++
 rtl/wb_stage.sv | 90 +++++++++
 tb/tb_wb_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pkg
//  Brief    : ER word field layout, entry types and packing helper for wb_stage
//  Revision : 1.0
// ============================================================================
package wb_pkg;

    localparam int ER_D_BITS = 16;
    localparam int ER_A_BITS = 3;

    localparam int WE_BIT    = 0;
    localparam int DEST_LSB  = 1;
    localparam int VAL_LSB   = DEST_LSB + ER_A_BITS;

    typedef struct packed {
        logic [ER_D_BITS-1:0] value;
        logic [ER_A_BITS-1:0] dest;
        logic                 we;
    } er_t;

    typedef struct packed {
        logic [ER_A_BITS-1:0] dest;
        logic [ER_D_BITS-1:0] value;
    } wb_entry_t;

    // Value field position for a non-default address width.
    function automatic int val_lsb(input int a_bits);
        return DEST_LSB + a_bits;
    endfunction

    function automatic er_t er_pack(input logic [ER_D_BITS-1:0] value,
                                    input logic [ER_A_BITS-1:0] dest,
                                    input logic                 we);
        er_t e;
        e.value = value;
        e.dest  = dest;
        e.we    = we;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : wb_queue
//  Brief    : In-order circular writeback buffer with pending mask and
//             youngest-match forwarding lookup over the live entries
//  Revision : 1.0
// ============================================================================
module wb_queue #(
    parameter int D_BITS = 16,
    parameter int A_BITS = 3,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [A_BITS-1:0]      push_dest,
    input  logic [D_BITS-1:0]      push_value,
    input  logic                   pop,
    output logic                   not_empty,
    output logic                   not_full,
    output logic [A_BITS-1:0]      head_dest,
    output logic [D_BITS-1:0]      head_value,
    output logic [(2**A_BITS)-1:0] pending,
    input  logic [A_BITS-1:0]      fwd_addr,
    output logic                   fwd_hit,
    output logic [D_BITS-1:0]      fwd_value
);
    import wb_pkg::*;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic [A_BITS-1:0] r_dest  [DEPTH];
    logic [D_BITS-1:0] r_value [DEPTH];

    logic [PW-1:0]     w_age_idx [DEPTH];
    logic [DEPTH-1:0]  w_live;

    // Modulo-DEPTH add; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] add_mod(input logic [PW-1:0] base,
                                              input logic [PW-1:0] off);
        logic [PW:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= (PW+1)'(DEPTH))
            s = s - (PW+1)'(DEPTH);
        return s[PW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push)
                r_wr_ptr <= add_mod(r_wr_ptr, PW'(1));
            if (pop)
                r_rd_ptr <= add_mod(r_rd_ptr, PW'(1));
            if (push && !pop)
                r_count <= r_count + CW'(1);
            else if (!push && pop)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_dest[r_wr_ptr]  <= push_dest;
            r_value[r_wr_ptr] <= push_value;
        end
    end

    // Slot k holds the k-th oldest entry; live when within the occupancy.
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_age
            assign w_age_idx[k] = add_mod(r_rd_ptr, PW'(k));
            assign w_live[k]    = (CW'(k) < r_count);
        end
    endgenerate

    always_comb begin
        pending   = '0;
        fwd_hit   = 1'b0;
        fwd_value = '0;
        // Oldest to youngest, so the last match is the youngest.
        for (int k = 0; k < DEPTH; k++) begin
            if (w_live[k]) begin
                pending[r_dest[w_age_idx[k]]] = 1'b1;
                if (r_dest[w_age_idx[k]] == fwd_addr) begin
                    fwd_hit   = 1'b1;
                    fwd_value = r_value[w_age_idx[k]];
                end
            end
        end
    end

    assign not_empty  = (r_count != '0);
    assign not_full   = (r_count < CW'(DEPTH));
    assign head_dest  = r_dest[r_rd_ptr];
    assign head_value = r_value[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Brief    : Writeback stage: ER handshake, drop filter, queued register-file
//             writes, pending mask, forwarding lookup and commit counter
//  Revision : 1.0
// ============================================================================
module wb_stage #(
    parameter int D_BITS   = 16,
    parameter int A_BITS   = 3,
    parameter int DEPTH    = 2,
    parameter int ZERO_REG = 0,
    parameter int CNT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     er_valid,
    output logic                     er_ready,
    input  logic [D_BITS+A_BITS:0]   er_data,
    output logic                     rf_we,
    output logic [A_BITS-1:0]        rf_addr,
    output logic [D_BITS-1:0]        rf_wdata,
    input  logic                     rf_ready,
    output logic [(2**A_BITS)-1:0]   pending,
    input  logic [A_BITS-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [D_BITS-1:0]        fwd_value,
    output logic [CNT_BITS-1:0]      wb_count
);
    import wb_pkg::*;

    localparam int C_VAL_LSB = val_lsb(A_BITS);

    logic                w_we;
    logic [A_BITS-1:0]   w_dest;
    logic [D_BITS-1:0]   w_value;
    logic                w_pop;
    logic                w_accept;
    logic                w_keep;
    logic                w_push;
    logic                w_not_empty;
    logic                w_not_full;
    logic [CNT_BITS-1:0] r_wb_count;

    assign w_we    = er_data[WE_BIT];
    assign w_dest  = er_data[DEST_LSB +: A_BITS];
    assign w_value = er_data[C_VAL_LSB +: D_BITS];

    // A full queue still accepts when the head drains in the same cycle.
    assign w_pop    = rf_we & rf_ready;
    assign er_ready = w_not_full | w_pop;
    assign w_accept = er_valid & er_ready;

    assign w_keep = w_we & ~((ZERO_REG != 0) && (w_dest == '0));
    assign w_push = w_accept & w_keep;

    wb_queue #(
        .D_BITS (D_BITS),
        .A_BITS (A_BITS),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .push_dest  (w_dest),
        .push_value (w_value),
        .pop        (w_pop),
        .not_empty  (w_not_empty),
        .not_full   (w_not_full),
        .head_dest  (rf_addr),
        .head_value (rf_wdata),
        .pending    (pending),
        .fwd_addr   (fwd_addr),
        .fwd_hit    (fwd_hit),
        .fwd_value  (fwd_value)
    );

    assign rf_we = w_not_empty;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_wb_count <= '0;
        else if (w_pop)
            r_wb_count <= r_wb_count + CNT_BITS'(1);
    end

    assign wb_count = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage
//  Brief    : Self-checking bench for wb_stage against a queue-based model
//  Revision : 1.0
// ============================================================================
module tb_wb_stage;
    import wb_pkg::*;

    localparam int D_BITS   = 16;
    localparam int A_BITS   = 3;
    localparam int DEPTH    = 2;
    localparam int CNT_BITS = 4;
    localparam int NUM_REGS = 2**A_BITS;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   er_valid = 1'b0;
    logic                   er_ready;
    logic [D_BITS+A_BITS:0] er_data = '0;
    logic                   rf_we;
    logic [A_BITS-1:0]      rf_addr;
    logic [D_BITS-1:0]      rf_wdata;
    logic                   rf_ready = 1'b0;
    logic [NUM_REGS-1:0]    pending;
    logic [A_BITS-1:0]      fwd_addr = '0;
    logic                   fwd_hit;
    logic [D_BITS-1:0]      fwd_value;
    logic [CNT_BITS-1:0]    wb_count;

    int        total = 0;
    int        bad   = 0;
    logic      rst_req = 1'b0;
    wb_entry_t q[$];
    int        m_cnt = 0;

    always #5 clk = ~clk;

    wb_stage #(
        .D_BITS   (D_BITS),
        .A_BITS   (A_BITS),
        .DEPTH    (DEPTH),
        .ZERO_REG (1),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .er_valid  (er_valid),
        .er_ready  (er_ready),
        .er_data   (er_data),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .rf_ready  (rf_ready),
        .pending   (pending),
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_value (fwd_value),
        .wb_count  (wb_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare against the model,
    // then advance the model to what the next rising edge commits.
    task automatic step(input logic v, input logic [D_BITS-1:0] val, input logic [A_BITS-1:0] dst,
                        input logic we, input logic rr, input logic [A_BITS-1:0] fa);
        logic [NUM_REGS-1:0] ep;
        logic                eh;
        logic [D_BITS-1:0]   ev;
        logic                pop_m;
        logic                acc_m;
        @(negedge clk);
        rst_n    = rst_req;
        er_valid = v;
        er_data  = er_pack(val, dst, we);
        rf_ready = rr;
        fwd_addr = fa;
        #1;
        ep = '0;
        eh = 1'b0;
        ev = '0;
        foreach (q[i]) begin
            ep[q[i].dest] = 1'b1;
            if (q[i].dest == fa) begin
                eh = 1'b1;
                ev = q[i].value;
            end
        end
        pop_m = (q.size() != 0) && rr;
        acc_m = v && ((q.size() < DEPTH) || pop_m);
        check("er_ready", er_ready, (q.size() < DEPTH) || pop_m);
        check("rf_we", rf_we, q.size() != 0);
        if (q.size() != 0) begin
            check("rf_addr", rf_addr, q[0].dest);
            check("rf_wdata", rf_wdata, q[0].value);
        end
        check("pending", pending, ep);
        check("fwd_hit", fwd_hit, eh);
        check("fwd_value", fwd_value, ev);
        check("wb_count", wb_count, m_cnt);
        if (!rst_req) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (pop_m) begin
                void'(q.pop_front());
                m_cnt = (m_cnt + 1) % (2**CNT_BITS);
            end
            if (acc_m && we && dst != 0)
                q.push_back('{dest: dst, value: val});
        end
    endtask

    task automatic idle(input logic rr, input logic [A_BITS-1:0] fa);
        step(1'b0, '0, '0, 1'b0, rr, fa);
    endtask

    initial begin
        // Reset with a valid word presented: nothing may be taken.
        rst_req = 1'b0;
        step(1'b1, 16'h1234, 3'd3, 1'b1, 1'b1, 3'd0);
        step(1'b1, 16'h1234, 3'd3, 1'b1, 1'b1, 3'd0);
        rst_req = 1'b1;
        idle(1'b1, 3'd3);
        check("rst_rf_we", rf_we, 0);
        check("rst_pending", pending, 0);
        check("rst_wb_count", wb_count, 0);

        // Single write.
        step(1'b1, 16'h00AB, 3'd5, 1'b1, 1'b1, 3'd0);
        idle(1'b1, 3'd5);
        check("t2_we", rf_we, 1);
        check("t2_addr", rf_addr, 5);
        check("t2_data", rf_wdata, 16'h00AB);
        check("t2_pending", pending, 8'b0010_0000);
        idle(1'b1, 3'd0);
        check("t2_we_off", rf_we, 0);
        check("t2_count", wb_count, 1);

        // Dropped words are still consumed.
        step(1'b1, 16'h5555, 3'd2, 1'b0, 1'b1, 3'd0);
        check("t3_rdy_we0", er_ready, 1);
        step(1'b1, 16'h6666, 3'd0, 1'b1, 1'b1, 3'd0);
        check("t3_rdy_r0", er_ready, 1);
        idle(1'b1, 3'd0);
        check("t3_we", rf_we, 0);
        check("t3_count", wb_count, 1);

        // Back-pressure, then simultaneous push and pop on a full queue.
        step(1'b1, 16'hA001, 3'd1, 1'b1, 1'b0, 3'd0);
        step(1'b1, 16'hA002, 3'd2, 1'b1, 1'b0, 3'd0);
        step(1'b1, 16'hA003, 3'd3, 1'b1, 1'b0, 3'd0);
        check("t4_full_rdy", er_ready, 0);
        step(1'b1, 16'hA003, 3'd3, 1'b1, 1'b1, 3'd0);
        check("t4_pushpop_rdy", er_ready, 1);
        check("t4_order1", rf_addr, 1);
        idle(1'b1, 3'd0);
        check("t4_order2", rf_addr, 2);
        idle(1'b1, 3'd0);
        check("t4_order3", rf_addr, 3);
        check("t4_data3", rf_wdata, 16'hA003);
        idle(1'b1, 3'd0);

        // Youngest-match forwarding.
        step(1'b1, 16'h1111, 3'd3, 1'b1, 1'b0, 3'd3);
        step(1'b1, 16'h2222, 3'd3, 1'b1, 1'b0, 3'd3);
        idle(1'b0, 3'd3);
        check("t5_hit", fwd_hit, 1);
        check("t5_value", fwd_value, 16'h2222);
        idle(1'b0, 3'd4);
        check("t5_miss_hit", fwd_hit, 0);
        check("t5_miss_value", fwd_value, 0);
        idle(1'b1, 3'd3);
        check("t5_first_out", rf_wdata, 16'h1111);
        idle(1'b1, 3'd3);
        idle(1'b1, 3'd3);

        // Counter wrap: 17 commits on a 4-bit counter.
        rst_req = 1'b0;
        idle(1'b1, 3'd0);
        rst_req = 1'b1;
        for (int i = 0; i < 17; i++)
            step(1'b1, 16'(i * 7 + 1), 3'((i % 7) + 1), 1'b1, 1'b1, 3'd0);
        idle(1'b1, 3'd0);
        idle(1'b1, 3'd0);
        check("t6_wrap", wb_count, 1);

        // Random traffic with occasional mid-operation resets.
        for (int i = 0; i < 1000; i++) begin
            rst_req = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            step(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 5) != 0), ($urandom_range(0, 2) != 0),
                 3'($urandom_range(0, 7)));
        end
        rst_req = 1'b1;
        idle(1'b1, 3'd0);
        idle(1'b1, 3'd0);
        idle(1'b1, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
